dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 116 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for a single-cycle core.
// Combinational load path, word-addressed RAM, LED register, synchronized
// switch input, sticky misaligned-store flag and an optional free-running
// cycle counter. The counter exists only when DMEM_RESPONDER_COUNTER_EN is
// defined; otherwise 0x1008 behaves like an unmapped address.
module dmem_responder #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [7:0]  Switches,
  output logic [7:0]  LEDs,
  output logic        MisalignErr
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [29:0] LED_WORD    = 30'h0000_0400; // 0x1000 >> 2
  localparam logic [29:0] SWITCH_WORD = 30'h0000_0401; // 0x1004 >> 2
  localparam logic [29:0] STATUS_WORD = 30'h0000_0403; // 0x100C >> 2
`ifdef DMEM_RESPONDER_COUNTER_EN
  localparam logic [29:0] COUNT_WORD  = 30'h0000_0402; // 0x1008 >> 2
`endif

  logic [31:0]   ram [DEPTH];
  logic [7:0]    led_q;
  logic [7:0]    sw_meta;
  logic [7:0]    sw_sync;
  logic          misalign_q;

  logic          aligned;
  logic          wr_ok;
  logic          wr_bad;
  logic          in_ram;
  logic [AW-1:0] word_idx;
  logic [29:0]   word_addr;

  // Address decode shared by the read mux and all write enables.
  assign aligned   = (Addr[1:0] == 2'b00);
  assign wr_ok     = MemWrite && aligned;
  assign wr_bad    = MemWrite && !aligned;
  assign in_ram    = (Addr[31:AW+2] == '0);
  assign word_idx  = Addr[AW+1:2];
  assign word_addr = Addr[31:2];

  assign LEDs        = led_q;
  assign MisalignErr = misalign_q;

`ifdef DMEM_RESPONDER_COUNTER_EN
  logic [31:0] cycle_cnt;

  // Free-running cycle counter; an aligned store replaces the increment.
  always_ff @(posedge clk) begin
    if (reset)
      cycle_cnt <= '0;
    else if (wr_ok && word_addr == COUNT_WORD)
      cycle_cnt <= WriteData;
    else
      cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

  // RAM write port: aligned, in range, and never while reset is held.
  // NOTE: the RAM array has no reset branch so it maps onto block RAM; its
  // contents deliberately survive reset, only the write is blocked.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok && in_ram)
      ram[word_idx] <= WriteData;
  end

  // LED register, switch synchronizer and sticky misalign flag.
  // NOTE: every sequential assignment is non-blocking so the two synchronizer
  // stages really form two flops instead of collapsing into one.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q      <= '0;
      sw_meta    <= '0;
      sw_sync    <= '0;
      misalign_q <= 1'b0;
    end else begin
      sw_meta <= Switches;
      sw_sync <= sw_meta;
      if (wr_ok && word_addr == LED_WORD)
        led_q <= WriteData[7:0];
      // Set takes priority over write-1-to-clear.
      if (wr_bad)
        misalign_q <= 1'b1;
      else if (wr_ok && word_addr == STATUS_WORD && WriteData[0])
        misalign_q <= 1'b0;
    end
  end

  // Combinational load mux; unmapped words return zero.
  // NOTE: ReadData gets a default before any branch so no path infers a latch.
  always_comb begin
    ReadData = '0;
    if (in_ram) begin
      ReadData = ram[word_idx];
    end else begin
      case (word_addr)
        LED_WORD:    ReadData = {24'b0, led_q};
        SWITCH_WORD: ReadData = {24'b0, sw_sync};
`ifdef DMEM_RESPONDER_COUNTER_EN
        COUNT_WORD:  ReadData = cycle_cnt;
`endif
        STATUS_WORD: ReadData = {31'b0, misalign_q};
        default:     ReadData = '0;
      endcase
    end
  end

endmodule
